// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the program-counter fetch block.
package pc_fetch_pkg;

   localparam int unsigned PC_W_DEF  = 10;
   localparam int unsigned OFF_W_DEF = 11;
   localparam int unsigned CNT_W     = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_e;

   typedef logic [PC_W_DEF-1:0] pc_t;

   // Saturating increment for the run-cycle counter
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/pc_fetch.sv
// Program-counter sequencer: IDLE/RUN/HALTED with relative branches and a run-cycle counter.
// Optional macro PC_BRANCH_RANGE_CHECK_EN halts on out-of-range branch targets instead of wrapping.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEF,
   parameter int unsigned OFF_W = OFF_W_DEF
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [PC_W-1:0]    StartAddr,
   input  logic               Stall,
   input  logic               Halt,
   input  logic               BranchTaken,
   input  logic [OFF_W-1:0]   TargetOffset,
   output logic [PC_W-1:0]    ProgCounter,
   output logic               Running,
   output logic               Done,
   output logic               BranchErr,
   output logic [CNT_W-1:0]   CycleCount
);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_RUN    = RUN;
   localparam logic [1:0] S_HALTED = HALTED;

   logic [1:0]       state, state_nxt;
   logic [PC_W-1:0]  pc, pc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             running, done;
   logic [PC_W-1:0]  br_pc;

`ifdef PC_BRANCH_RANGE_CHECK_EN
   // Sum kept wide enough that any pc/offset pair is exact, so the range test is reliable
   localparam int unsigned SUM_W = ((OFF_W > PC_W) ? OFF_W : PC_W) + 2;

   logic signed [SUM_W-1:0] br_sum;
   logic                    br_oor;
   logic                    err, err_nxt;

   assign br_sum = $signed({{(SUM_W-PC_W){1'b0}}, pc}) + SUM_W'($signed(TargetOffset));
   assign br_pc  = br_sum[PC_W-1:0];
   assign br_oor = (br_sum[SUM_W-1:PC_W] != '0);
   assign BranchErr = err;
`else
   assign br_pc     = pc + PC_W'($signed(TargetOffset));
   assign BranchErr = 1'b0;
`endif

   // Next-state and datapath update
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      cnt_nxt   = cnt;
`ifdef PC_BRANCH_RANGE_CHECK_EN
      err_nxt   = err;
`endif
      case (state)
         S_IDLE, S_HALTED: begin
            if (Start) begin
               state_nxt = S_RUN;
               pc_nxt    = StartAddr;
               cnt_nxt   = '0;
`ifdef PC_BRANCH_RANGE_CHECK_EN
               err_nxt   = 1'b0;
`endif
            end
         end
         S_RUN: begin
            cnt_nxt = sat_inc(cnt);
            if (Halt) begin
               state_nxt = S_HALTED;
            end else if (!Stall) begin
               if (BranchTaken) begin
`ifdef PC_BRANCH_RANGE_CHECK_EN
                  if (br_oor) begin
                     err_nxt   = 1'b1;
                     state_nxt = S_HALTED;
                  end else begin
                     pc_nxt = br_pc;
                  end
`else
                  pc_nxt = br_pc;
`endif
               end else begin
                  pc_nxt = pc + PC_W'(1);
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register; status flags are decoded from the next state so they stay registered
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= S_IDLE;
         pc      <= '0;
         cnt     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
`ifdef PC_BRANCH_RANGE_CHECK_EN
         err     <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         cnt     <= cnt_nxt;
         running <= (state_nxt == S_RUN);
         done    <= (state_nxt == S_HALTED);
`ifdef PC_BRANCH_RANGE_CHECK_EN
         err     <= err_nxt;
`endif
      end
   end

   assign ProgCounter = pc;
   assign CycleCount  = cnt;
   assign Running     = running;
   assign Done        = done;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch (both with and without PC_BRANCH_RANGE_CHECK_EN).
module tb_pc_fetch;

   localparam int unsigned PC_W  = 10;
   localparam int unsigned OFF_W = 11;

   logic              Clk;
   logic              Reset;
   logic              Start;
   logic [PC_W-1:0]   StartAddr;
   logic              Stall;
   logic              Halt;
   logic              BranchTaken;
   logic [OFF_W-1:0]  TargetOffset;
   logic [PC_W-1:0]   ProgCounter;
   logic              Running;
   logic              Done;
   logic              BranchErr;
   logic [15:0]       CycleCount;

   int checks = 0;
   int errors = 0;

   pc_fetch #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Start        (Start),
      .StartAddr    (StartAddr),
      .Stall        (Stall),
      .Halt         (Halt),
      .BranchTaken  (BranchTaken),
      .TargetOffset (TargetOffset),
      .ProgCounter  (ProgCounter),
      .Running      (Running),
      .Done         (Done),
      .BranchErr    (BranchErr),
      .CycleCount   (CycleCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_status(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                               input logic run, input logic dn, input logic err);
      check({tag, ".pc"},  32'(ProgCounter), pc);
      check({tag, ".cnt"}, 32'(CycleCount),  cnt);
      check({tag, ".run"}, 32'(Running),     32'(run));
      check({tag, ".done"},32'(Done),        32'(dn));
      check({tag, ".err"}, 32'(BranchErr),   32'(err));
   endtask

   task automatic launch(input logic [PC_W-1:0] addr);
      Start = 1'b1; StartAddr = addr;
      step();
      Start = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; StartAddr = '0; Stall = 1'b0;
      Halt = 1'b0; BranchTaken = 1'b0; TargetOffset = '0;
      step();
      check_status("reset", 0, 0, 0, 0, 0);
      Reset = 1'b0;
      step();
      check_status("idle_hold", 0, 0, 0, 0, 0);

      // Sequential run from 5
      launch(10'd5);
      check_status("start5", 5, 0, 1, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         check($sformatf("seq%0d.pc", i), 32'(ProgCounter), 32'(5 + i));
      end
      check_status("seq_end", 9, 4, 1, 0, 0);

      // Halt, then HALTED holds
      Halt = 1'b1; step(); Halt = 1'b0;
      check_status("halt9", 9, 5, 0, 1, 0);
      step();
      check_status("halted_hold", 9, 5, 0, 1, 0);

      // Backward branch 400-370; Start during RUN must be ignored
      launch(10'd400);
      check_status("start400", 400, 0, 1, 0, 0);
      BranchTaken = 1'b1; TargetOffset = 11'(-370); Start = 1'b1; StartAddr = 10'd77;
      step();
      BranchTaken = 1'b0; Start = 1'b0;
      check_status("br400", 30, 1, 1, 0, 0);

      Halt = 1'b1; step(); Halt = 1'b0;
      launch(10'd360);
      BranchTaken = 1'b1; TargetOffset = 11'(-357);
      step();
      BranchTaken = 1'b0;
      check_status("br360", 3, 1, 1, 0, 0);
      step();
      check("inc_after_br.pc", 32'(ProgCounter), 4);

      // Stall suppresses the branch
      Halt = 1'b1; step(); Halt = 1'b0;
      launch(10'd10);
      Stall = 1'b1; BranchTaken = 1'b1; TargetOffset = 11'(-370);
      step();
      check_status("stall1", 10, 1, 1, 0, 0);
      step();
      check_status("stall2", 10, 2, 1, 0, 0);
      Stall = 1'b0;
      step();
      BranchTaken = 1'b0;
`ifdef PC_BRANCH_RANGE_CHECK_EN
      check_status("oor_neg", 10, 3, 0, 1, 1);
      step();
      check_status("oor_hold", 10, 3, 0, 1, 1);
      launch(10'd1000);
      check_status("err_clear", 1000, 0, 1, 0, 0);
      BranchTaken = 1'b1; TargetOffset = 11'd100;
      step();
      BranchTaken = 1'b0;
      check_status("oor_pos", 1000, 1, 0, 1, 1);
`else
      check_status("wrap_neg", 664, 3, 1, 0, 0);
      Halt = 1'b1; step(); Halt = 1'b0;
      launch(10'd1000);
      BranchTaken = 1'b1; TargetOffset = 11'd100;
      step();
      BranchTaken = 1'b0;
      check_status("wrap_pos", 76, 1, 1, 0, 0);
      Halt = 1'b1; step(); Halt = 1'b0;
      check_status("halt76", 76, 2, 0, 1, 0);
`endif

      // Halt beats Stall and BranchTaken
      launch(10'd50);
      Halt = 1'b1; BranchTaken = 1'b1; Stall = 1'b1; TargetOffset = 11'd5;
      step();
      Halt = 1'b0; BranchTaken = 1'b0; Stall = 1'b0;
      check_status("halt_prio", 50, 1, 0, 1, 0);
      launch(10'd0);
      check_status("restart0", 0, 0, 1, 0, 0);

      // Reset mid-run wins over Start
      Halt = 1'b1; step(); Halt = 1'b0;
      launch(10'd123);
      step();
      check("pre_reset.pc", 32'(ProgCounter), 124);
      Reset = 1'b1; Start = 1'b1; StartAddr = 10'd200;
      step();
      check_status("mid_reset", 0, 0, 0, 0, 0);
      Reset = 1'b0; Start = 1'b0;
      step();
      check_status("post_reset", 0, 0, 0, 0, 0);

      // Counter saturation, PC frozen by Stall
      launch(10'd7);
      Stall = 1'b1;
      repeat (65534) @(posedge Clk);
      #1;
      check_status("cnt_fffe", 7, 16'hFFFE, 1, 0, 0);
      step();
      check("cnt_ffff", 32'(CycleCount), 32'hFFFF);
      step();
      step();
      check("cnt_sat", 32'(CycleCount), 32'hFFFF);
      Stall = 1'b0;
      Halt = 1'b1; step(); Halt = 1'b0;
      check_status("sat_halt", 7, 16'hFFFF, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have these parameters:
- PC_W, 10, program-counter width (instruction memory depth 2^PC_W).
- OFF_W, 11, signed branch-offset width; matches the branch-target LUT output.

REQ-002 The block SHALL have these ports:
- Clk  in  1  sole clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level; launches a program run from IDLE or HALTED.
- StartAddr  in  PC_W  PC value loaded on launch.
- Stall  in  1  freezes the PC for the current cycle.
- Halt  in  1  decoded halt instruction at the current PC.
- BranchTaken  in  1  decoded bnzl whose condition is true.
- TargetOffset  in  OFF_W  signed two's-complement offset from the branch-target LUT.
- ProgCounter  out  PC_W  current instruction address.
- Running  out  1  high in RUN.
- Done  out  1  high in HALTED.
- BranchErr  out  1  sticky out-of-range flag (see REQ-013).
- CycleCount  out  16  cycles spent in RUN.

Function
REQ-003 The block SHALL implement the states IDLE, RUN and HALTED.
REQ-004 In IDLE or HALTED, Start=1 SHALL do all of the following on the next edge:
- load ProgCounter with StartAddr;
- clear CycleCount and BranchErr;
- enter RUN.
REQ-005 In RUN, Start SHALL be ignored.
REQ-006 In RUN with Stall=0 and Halt=0, the next ProgCounter SHALL be:
- ProgCounter + sign-extended TargetOffset when BranchTaken=1;
- ProgCounter + 1 otherwise.
REQ-007 The sum SHALL be computed at PC_W+1 bits signed and then truncated modulo 2^PC_W, unless REQ-013 applies.
REQ-008 In RUN with Halt=1, the block SHALL enter HALTED on the next edge with ProgCounter unchanged; Halt SHALL take priority over Stall and BranchTaken.
REQ-009 In RUN with Stall=1 and Halt=0, ProgCounter SHALL hold and BranchTaken SHALL be ignored; the decoder re-presents it on the following cycle.
REQ-010 CycleCount SHALL increment on every edge spent in RUN, including stalled cycles and the edge that leaves RUN; it SHALL saturate at 16'hFFFF.
REQ-011 The outputs SHALL be registered state decodes with zero combinational path from the inputs: Running = (state==RUN), Done = (state==HALTED).
REQ-012 In IDLE and HALTED, ProgCounter and CycleCount SHALL hold their values.

Reset
REQ-014 Reset=1 SHALL take precedence over every other input, including mid-run.
REQ-015 On the next edge after Reset=1, the block SHALL be in this state:
- state IDLE;
- ProgCounter=0, CycleCount=0;
- BranchErr=0, Running=0, Done=0.

Configuration
REQ-013 With macro PC_BRANCH_RANGE_CHECK_EN defined, a taken, unstalled branch whose signed sum is <0 or >2^PC_W-1 SHALL:
- set BranchErr;
- hold ProgCounter;
- enter HALTED.
Without the macro, BranchErr SHALL be tied to 0 and the sum SHALL wrap per REQ-007.

Structure
REQ-016 A shared package SHALL hold:
- the PC_W and OFF_W defaults;
- the state enum (IDLE, RUN, HALTED) as a typedef;
- a pc_t typedef of PC_W bits.
REQ-017 The block SHALL contain no sub-module; the branch-target LUT stays an external sibling whose output drives TargetOffset.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Reset, then Start with StartAddr=5, no branches, 4 cycles -> ProgCounter 5,6,7,8,9; Running=1; CycleCount=4.
- PC=400, BranchTaken=1, TargetOffset=-370 -> ProgCounter=30 next cycle; PC=360, offset=-357 -> 3.
- PC=10, Stall=1 with BranchTaken=1 and offset=-370 for 2 cycles -> PC holds at 10, CycleCount still increments.
- PC=10, offset=-370, BranchTaken=1:
  - with PC_BRANCH_RANGE_CHECK_EN -> BranchErr=1, Done=1, PC=10;
  - without the macro -> PC=664.
- Halt and BranchTaken asserted together at PC=50 -> HALTED, PC=50, Done=1; then Start with StartAddr=0 -> RUN, PC=0, CycleCount=0.
- Reset asserted mid-run at PC=123 -> next cycle IDLE, PC=0, all outputs 0; Start not required to clear.
